button_conditioner: RTL



---
 rtl/button_pkg.sv | 18 +
 rtl/button_channel.sv | 148 ++++++++++++++
 rtl/button_conditioner.sv | 36 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants, state encoding and timing helpers for the push-button conditioner.
package button_pkg;

    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        REL_STABLE = 2'd0,
        REL_ARMING = 2'd1,
        PRS_STABLE = 2'd2,
        PRS_ARMING = 2'd3
    } btn_state_t;

    // Whole milliseconds to clock cycles at the given clock frequency.
    function automatic int unsigned cycles_from_ms(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, debounce state machine,
// registered clean level, press/release pulses and a one-shot long-press pulse.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = cycles_from_ms(SYS_CLK_HZ, 20),
    parameter int unsigned LONG_PRESS_CYCLES = cycles_from_ms(SYS_CLK_HZ, 1000),
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic sys_clk_50m,
    input  logic sys_rst,
    input  logic button,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic              s1;
    logic              s2;
    btn_state_t        state_q;
    btn_state_t        state_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              long_done_q;
    logic              long_done_d;
    logic              level_d;
    logic              press_d;
    logic              release_d;
    logic              long_d;

    // Synchroniser; reset value is the released level.
    always_ff @(posedge sys_clk_50m) begin
        if (sys_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= button ^ ACTIVE_LOW;
            s2 <= s1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk_50m) begin
        if (sys_rst) begin
            state_q          <= REL_STABLE;
            db_cnt_q         <= '0;
            hold_cnt_q       <= '0;
            long_done_q      <= 1'b0;
            level            <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            state_q          <= state_d;
            db_cnt_q         <= db_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            long_done_q      <= long_done_d;
            level            <= level_d;
            press_pulse      <= press_d;
            release_pulse    <= release_d;
            long_press_pulse <= long_d;
        end
    end

    // Next-state logic: any cycle where s2 matches the accepted level restarts the count.
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        level_d     = level;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            REL_STABLE: begin
                if (s2) begin
                    state_d  = REL_ARMING;
                    db_cnt_d = DB_W'(1);
                end else begin
                    db_cnt_d = '0;
                end
            end
            REL_ARMING: begin
                if (!s2) begin
                    state_d  = REL_STABLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = PRS_STABLE;
                    db_cnt_d = '0;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRS_STABLE: begin
                if (!s2) begin
                    state_d  = PRS_ARMING;
                    db_cnt_d = DB_W'(1);
                end else begin
                    db_cnt_d = '0;
                end
            end
            PRS_ARMING: begin
                if (s2) begin
                    state_d  = PRS_STABLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = REL_STABLE;
                    db_cnt_d  = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = REL_STABLE;
                db_cnt_d = '0;
                level_d  = 1'b0;
            end
        endcase

        // Release wins over a long-press that would land on the same edge.
        if (!level || release_d) begin
            hold_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (!long_done_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw push-button pins into debounced levels and press/release/long-press pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS       = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = cycles_from_ms(SYS_CLK_HZ, 20),
    parameter int unsigned LONG_PRESS_CYCLES = cycles_from_ms(SYS_CLK_HZ, 1000),
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic                   sys_clk_50m,
    input  logic                   sys_rst,
    input  logic [NUM_BUTTONS-1:0] buttons,
    output logic [NUM_BUTTONS-1:0] buttons_level,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_press_pulse
);

    // Channels are fully independent.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW)
        ) u_ch (
            .sys_clk_50m     (sys_clk_50m),
            .sys_rst         (sys_rst),
            .button          (buttons[i]),
            .level           (buttons_level[i]),
            .press_pulse     (press_pulse[i]),
            .release_pulse   (release_pulse[i]),
            .long_press_pulse(long_press_pulse[i])
        );
    end

endmodule
